// File: rtl/simd_shift64_pkg.sv
// simd_shift64_pkg: shared widths and direction encodings for the SIMD shifter
package simd_shift64_pkg;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam int DATA_W = 64;
  localparam int LANE_W = 32;
  localparam int AMT_W = 6;
endpackage

// File: rtl/simd_shift64_if.sv
// simd_shift64_if: operand/control bus and registered result of the SIMD shifter
interface simd_shift64_if;
  import simd_shift64_pkg::*;
  logic in_valid;
  logic mode_unified;
  logic uni_dir;
  logic uni_arith;
  logic hi_dir;
  logic hi_arith;
  logic lo_dir;
  logic lo_arith;
  logic [2*AMT_W-1:0] shift_amt;
  logic [DATA_W-1:0] in_bus;
  logic out_valid;
  logic [DATA_W-1:0] out_bus;
  modport master (
    output in_valid, mode_unified, uni_dir, uni_arith, hi_dir, hi_arith, lo_dir, lo_arith, shift_amt, in_bus,
    input out_valid, out_bus
  );
  modport slave (
    input in_valid, mode_unified, uni_dir, uni_arith, hi_dir, hi_arith, lo_dir, lo_arith, shift_amt, in_bus,
    output out_valid, out_bus
  );
endinterface

// File: rtl/simd_shift_lane.sv
// simd_shift_lane: combinational W-bit shifter; amounts >= W saturate to the fill pattern
module simd_shift_lane
  import simd_shift64_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic [W-1:0]     data,
  input  logic             dir,
  input  logic             arith,
  input  logic             fill,
  input  logic [AMT_W-1:0] amt,
  output logic [W-1:0]     res
);
  logic f;
  logic over;
  logic [W-1:0] vacated;
  assign f = (dir == DIR_RIGHT) & arith & fill;
  assign over = {1'b0, amt} >= (AMT_W+1)'(W);
  assign vacated = ~({W{1'b1}} >> amt);
  assign res = over ? {W{f}} : (dir == DIR_RIGHT) ? ((data >> amt) | ({W{f}} & vacated)) : (data << amt);
endmodule

// File: rtl/simd_shift64.sv
// simd_shift64: registered 64-bit barrel shifter, unified or two independent 32-bit lanes
module simd_shift64
  import simd_shift64_pkg::*;
(
  input logic clk,
  input logic rst,
  simd_shift64_if.slave bus
);
  logic [DATA_W-1:0] uni_res;
  logic [LANE_W-1:0] hi_res;
  logic [LANE_W-1:0] lo_res;
  logic [DATA_W-1:0] res;
  simd_shift_lane #(.W(DATA_W)) u_uni (
    .data  (bus.in_bus),
    .dir   (bus.uni_dir),
    .arith (bus.uni_arith),
    .fill  (bus.in_bus[DATA_W-1]),
    .amt   (bus.shift_amt[AMT_W-1:0]),
    .res   (uni_res)
  );
  simd_shift_lane #(.W(LANE_W)) u_hi (
    .data  (bus.in_bus[DATA_W-1:LANE_W]),
    .dir   (bus.hi_dir),
    .arith (bus.hi_arith),
    .fill  (bus.in_bus[DATA_W-1]),
    .amt   (bus.shift_amt[2*AMT_W-1:AMT_W]),
    .res   (hi_res)
  );
  simd_shift_lane #(.W(LANE_W)) u_lo (
    .data  (bus.in_bus[LANE_W-1:0]),
    .dir   (bus.lo_dir),
    .arith (bus.lo_arith),
    .fill  (bus.in_bus[LANE_W-1]),
    .amt   (bus.shift_amt[AMT_W-1:0]),
    .res   (lo_res)
  );
  assign res = bus.mode_unified ? uni_res : {hi_res, lo_res};
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_bus <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.out_bus <= res;
    end
  end
endmodule

// File: tb/tb_simd_shift64.sv
// tb_simd_shift64: directed and randomized checks of simd_shift64 against an arithmetic reference
module tb_simd_shift64;
  logic clk = 1'b0;
  logic rst;
  int vecs = 0;
  int errs = 0;
  logic [63:0] exp_bus;
  logic exp_v;

  simd_shift64_if bus ();
  simd_shift64 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] lane_ref(input logic [31:0] x, input logic dir, input logic ar, input int a);
    if (!dir) return (a >= 32) ? 32'd0 : x << a;
    if (!ar) return (a >= 32) ? 32'd0 : x >> a;
    return (a >= 32) ? {32{x[31]}} : 32'($signed(x) >>> a);
  endfunction

  function automatic logic [63:0] model(input logic mu, ud, ua, hd, ha, ld, la, input logic [11:0] amt, input logic [63:0] d);
    int a;
    a = int'(amt[5:0]);
    if (mu) begin
      if (!ud) return d << a;
      if (ua) return 64'($signed(d) >>> a);
      return d >> a;
    end
    return {lane_ref(d[63:32], hd, ha, int'(amt[11:6])), lane_ref(d[31:0], ld, la, a)};
  endfunction

  task automatic drive(input logic v, mu, ud, ua, hd, ha, ld, la, input logic [11:0] amt, input logic [63:0] d);
    bus.in_valid = v;
    bus.mode_unified = mu;
    bus.uni_dir = ud;
    bus.uni_arith = ua;
    bus.hi_dir = hd;
    bus.hi_arith = ha;
    bus.lo_dir = ld;
    bus.lo_arith = la;
    bus.shift_amt = amt;
    bus.in_bus = d;
    if (v) exp_bus = model(mu, ud, ua, hd, ha, ld, la, amt, d);
    exp_v = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 12'd5, 64'h1234_5678_9ABC_DEF0);
    chk("reset_bus", bus.out_bus, 64'd0);
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    exp_bus = 64'd0;
    drive(1, 0, 0, 0, 1, 1, 0, 0, {6'd2, 6'd3}, 64'hFEDC_BA98_7654_3210);
    chk("split_a", bus.out_bus, 64'hFFB7_2EA6_B2A1_9080);
    chk("split_a_valid", 64'(bus.out_valid), 64'd1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, {6'd1, 6'd4}, 64'hFEDC_BA98_7654_3210);
    chk("split_b", bus.out_bus, 64'hFDB9_7530_0765_4321);
    drive(1, 1, 0, 1, 1, 1, 1, 1, 12'd0, 64'hFEDC_BA98_7654_3210);
    chk("uni_left_0", bus.out_bus, 64'hFEDC_BA98_7654_3210);
    drive(1, 1, 0, 1, 0, 0, 0, 0, 12'd4, 64'hFEDC_BA98_7654_3210);
    chk("uni_left_4", bus.out_bus, 64'hEDCB_A987_6543_2100);
    drive(1, 1, 0, 0, 0, 0, 0, 0, {6'd63, 6'd40}, 64'hFEDC_BA98_7654_3210);
    chk("uni_left_40", bus.out_bus, 64'h5432_1000_0000_0000);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 12'd5, 64'hFEDC_BA98_7654_3210);
    chk("uni_lsr_5", bus.out_bus, 64'h07F6_E5D4_C3B2_A190);
    drive(1, 1, 1, 0, 1, 1, 1, 1, 12'd35, 64'hFEDC_BA98_7654_3210);
    chk("uni_lsr_35", bus.out_bus, 64'h0000_0000_1FDB_9753);
    drive(1, 1, 1, 1, 0, 0, 0, 0, 12'd10, 64'hF000_0000_A000_0000);
    chk("uni_asr_10", bus.out_bus, 64'hFFFC_0000_0028_0000);
    drive(1, 1, 1, 1, 0, 0, 0, 0, 12'd40, 64'hF000_0000_A000_0000);
    chk("uni_asr_40", bus.out_bus, 64'hFFFF_FFFF_FFF0_0000);
    drive(1, 1, 1, 1, 0, 0, 0, 0, 12'd63, 64'hF000_0000_A000_0000);
    chk("uni_asr_63", bus.out_bus, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 0, 0, 0, 1, 1, 1, 1, {6'd40, 6'd40}, 64'h8000_0001_8000_0000);
    chk("split_asr_40", bus.out_bus, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 0, 0, 0, 1, 0, 0, 0, {6'd40, 6'd33}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("split_over_zero", bus.out_bus, 64'd0);
    drive(1, 0, 0, 0, 1, 1, 1, 1, {6'd40, 6'd40}, 64'h7FFF_FFFF_1234_5678);
    chk("split_asr_pos", bus.out_bus, 64'd0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 12'd8, 64'h0000_0000_0000_00AB);
    chk("pre_hold", bus.out_bus, 64'h0000_0000_0000_AB00);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 12'd1, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("hold_bus", bus.out_bus, 64'h0000_0000_0000_AB00);
    chk("hold_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 12'd1, 64'h1111_1111_1111_1111);
    chk("midrst_bus", bus.out_bus, 64'd0);
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    exp_bus = 64'd0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom), {$urandom, $urandom});
      chk("rand_bus", bus.out_bus, exp_bus);
      chk("rand_valid", 64'(bus.out_valid), 64'(exp_v));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/simd_shift64.md
Name: simd_shift64

Overview:
- Registered 64-bit barrel shifter for the execute-stage SIMD/ALU path.
- Unified mode: one 64-bit shift.
- Split mode: two independent 32-bit lanes (hi = bits 63:32, lo = bits 31:0), each with its own direction, arithmetic flag and amount.
- Result is registered with one-cycle latency.

Parameters:
- none (widths fixed: 64-bit bus, 32-bit lanes, 12-bit amount field)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand/control valid this cycle
- mode_unified  input  1  1 = single 64-bit shift; 0 = two 32-bit lane shifts
- uni_dir  input  1  unified direction: 0 = left, 1 = right
- uni_arith  input  1  unified right-shift type: 1 = arithmetic, 0 = logical
- hi_dir  input  1  hi-lane direction (split mode), 0 = left, 1 = right
- hi_arith  input  1  hi-lane arithmetic flag (split mode)
- lo_dir  input  1  lo-lane direction (split mode)
- lo_arith  input  1  lo-lane arithmetic flag (split mode)
- shift_amt  input  12  unified: [5:0] = amount; split: [11:6] = hi amount, [5:0] = lo amount
- in_bus  input  64  operand
- out_valid  output  1  registered copy of in_valid
- out_bus  output  64  registered shift result

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - On a clk edge with rst=1, out_bus <= 0 and out_valid <= 0.
  - rst overrides any in-flight operation; that result is discarded.
- Latency:
  - Result for inputs sampled at edge N appears on out_bus after edge N.
  - No handshake or backpressure; a new operation may be issued every cycle.
  - out_bus updates only when in_valid=1 and holds its value otherwise.
  - out_valid <= in_valid every cycle.
- Unified mode (mode_unified=1):
  - amount = shift_amt[5:0] (0..63); shift_amt[11:6] ignored; hi_*/lo_* ignored.
  - uni_dir=0: out = in_bus << amount, zero fill; uni_arith ignored for left shifts.
  - uni_dir=1, uni_arith=0: logical right, zero fill from bit 63.
  - uni_dir=1, uni_arith=1: arithmetic right, fill with in_bus[63].
  - Shifts cross the 32-bit boundary freely.
  - amount=0 passes the operand through unchanged.
- Split mode (mode_unified=0):
  - lo lane: operand in_bus[31:0], amount shift_amt[5:0], controls lo_dir/lo_arith → out[31:0].
  - hi lane: operand in_bus[63:32], amount shift_amt[11:6], controls hi_dir/hi_arith → out[63:32].
  - No bits cross between lanes; the arithmetic fill uses the lane's own bit 31 (in_bus[63] for hi, in_bus[31] for lo).
  - uni_* ignored.
  - Lane amount >= 32:
    - left or logical right → lane result all zeros;
    - arithmetic right → lane result all copies of the lane sign bit.
- Mode, direction and amount are all sampled on the same edge as the operand; no state is carried between operations.

Decomposition:
- Shared package: constants DIR_LEFT=0, DIR_RIGHT=1, DATA_W=64, LANE_W=32, AMT_W=6.
- One natural sub-module, simd_shift_lane: a combinational N-bit shifter with dir, arith, amount and a fill-bit input.
- Build the unified path either from a 64-bit instance, or from two 32-bit instances with cross-lane carry; choose either, provided the results are bit-exact.
- The top level holds the mode muxing and the output/valid registers.

Test Plan:
- Split: in=FEDCBA9876543210, lo left 3, hi arith right 2, shift_amt={6'd2,6'd3} → out_bus=FFB72EA6B2A19080 one cycle later.
- Split: same in, lo logical right 4, hi left 1, shift_amt={6'd1,6'd4} → FDB9753007654321.
- Unified left on in=FEDCBA9876543210:
  - amt 0 → FEDCBA9876543210
  - amt 4 → EDCBA98765432100
  - amt 40 → 5432100000000000
- Unified logical right on in=FEDCBA9876543210:
  - amt 5 → 07F6E5D4C3B2A190
  - amt 35 → 000000001FDB9753
- Unified arithmetic right on in=F0000000A0000000:
  - amt 10 → FFFC000000280000
  - amt 40 → FFFFFFFFFFF00000
  - amt 63 → FFFFFFFFFFFFFFFF
- Control: rst=1 mid-stream → out_bus=0 and out_valid=0 after the edge; in_valid=0 → out_bus holds its previous value; split lane amount 40 with arithmetic right on a negative lane → lane all ones.
